// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared widths, inside-opcode and RV32I major-opcode constants
package decode_stage_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int REG_TAG_WIDTH       = 5;
  localparam int INSIDE_OPCODE_WIDTH = 6;
  localparam int OPCODE_WIDTH        = 7;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = 7'b0110011;

  // NOP is zero so cleared storage reads back as a NOP head
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] NOP   = 6'd0;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] LUI   = 6'd1;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] AUIPC = 6'd2;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] JAL   = 6'd3;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] JALR  = 6'd4;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] BEQ   = 6'd5;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] BNE   = 6'd6;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] BLT   = 6'd7;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] BGE   = 6'd8;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] BLTU  = 6'd9;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] BGEU  = 6'd10;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] LB    = 6'd11;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] LH    = 6'd12;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] LW    = 6'd13;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] LBU   = 6'd14;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] LHU   = 6'd15;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SB    = 6'd16;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SH    = 6'd17;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SW    = 6'd18;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] ADDI  = 6'd19;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SLTI  = 6'd20;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SLTIU = 6'd21;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] XORI  = 6'd22;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] ORI   = 6'd23;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] ANDI  = 6'd24;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SLLI  = 6'd25;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SRLI  = 6'd26;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SRAI  = 6'd27;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] ADD   = 6'd28;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SUB   = 6'd29;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SLL   = 6'd30;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SLT   = 6'd31;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SLTU  = 6'd32;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] XOR   = 6'd33;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] OR    = 6'd34;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] AND   = 6'd35;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SRL   = 6'd36;
  localparam logic [INSIDE_OPCODE_WIDTH-1:0] SRA   = 6'd37;

  typedef struct packed {
    logic [INSIDE_OPCODE_WIDTH-1:0] op;
    logic [REG_TAG_WIDTH-1:0]       rd;
    logic [REG_TAG_WIDTH-1:0]       rs1;
    logic [REG_TAG_WIDTH-1:0]       rs2;
    logic [DATA_WIDTH-1:0]          imm;
    logic                           illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and issue-side handshake bundle of the decode stage
interface decode_stage_if #(
  parameter int PC_W = 32
);
  import decode_stage_pkg::*;

  logic                           in_fetcher_valid;
  logic [DATA_WIDTH-1:0]          in_fetcher_instr;
  logic [PC_W-1:0]                in_fetcher_pc;
  logic                           out_fetcher_ready;
  logic                           in_flush;
  logic                           in_issue_ready;
  logic                           out_valid;
  logic [INSIDE_OPCODE_WIDTH-1:0] out_op;
  logic [REG_TAG_WIDTH-1:0]       out_rd;
  logic [REG_TAG_WIDTH-1:0]       out_rs1;
  logic [REG_TAG_WIDTH-1:0]       out_rs2;
  logic [DATA_WIDTH-1:0]          out_imm;
  logic [PC_W-1:0]                out_pc;
  logic                           out_illegal;

  modport slave (
    input  in_fetcher_valid, in_fetcher_instr, in_fetcher_pc, in_flush, in_issue_ready,
    output out_fetcher_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_illegal
  );

  modport master (
    output in_fetcher_valid, in_fetcher_instr, in_fetcher_pc, in_flush, in_issue_ready,
    input  out_fetcher_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_illegal
  );

endinterface

// File: rtl/decode_stage_decode_logic.sv
// rtl/decode_stage_decode_logic.sv - combinational RV32I decoder to inside opcode, tags, immediate
module decode_logic
  import decode_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] instr,
  output dec_t                  dec
);

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [DATA_WIDTH-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic                    ill;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    dec     = '0;
    ill     = FALSE;
    dec.rd  = instr[11:7];
    dec.rs1 = instr[19:15];
    case (opcode)
      OPC_LUI:   begin dec.op = LUI;   dec.rs1 = '0; dec.imm = imm_u; end
      OPC_AUIPC: begin dec.op = AUIPC; dec.rs1 = '0; dec.imm = imm_u; end
      OPC_JAL:   begin dec.op = JAL;   dec.rs1 = '0; dec.imm = imm_j; end
      OPC_JALR: begin
        dec.op  = JALR;
        dec.imm = imm_i;
        ill     = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.rd  = '0;
        dec.rs2 = instr[24:20];
        dec.imm = imm_b;
        case (funct3)
          3'b000:  dec.op = BEQ;
          3'b001:  dec.op = BNE;
          3'b100:  dec.op = BLT;
          3'b101:  dec.op = BGE;
          3'b110:  dec.op = BLTU;
          3'b111:  dec.op = BGEU;
          default: ill = TRUE;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i;
        case (funct3)
          3'b000:  dec.op = LB;
          3'b001:  dec.op = LH;
          3'b010:  dec.op = LW;
          3'b100:  dec.op = LBU;
          3'b101:  dec.op = LHU;
          default: ill = TRUE;
        endcase
      end
      OPC_STORE: begin
        dec.rd  = '0;
        dec.rs2 = instr[24:20];
        dec.imm = imm_s;
        case (funct3)
          3'b000:  dec.op = SB;
          3'b001:  dec.op = SH;
          3'b010:  dec.op = SW;
          default: ill = TRUE;
        endcase
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i;
        case (funct3)
          3'b000: dec.op = ADDI;
          3'b010: dec.op = SLTI;
          3'b011: dec.op = SLTIU;
          3'b100: dec.op = XORI;
          3'b110: dec.op = ORI;
          3'b111: dec.op = ANDI;
          3'b001: begin
            dec.op  = SLLI;
            dec.imm = imm_sh;
            ill     = (funct7 != 7'h00);
          end
          default: begin
            dec.op  = (funct7 == 7'h20) ? SRAI : SRLI;
            dec.imm = imm_sh;
            ill     = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        endcase
      end
      OPC_OP: begin
        dec.rs2 = instr[24:20];
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec.op = ADD;
          {7'h20, 3'b000}: dec.op = SUB;
          {7'h00, 3'b001}: dec.op = SLL;
          {7'h00, 3'b010}: dec.op = SLT;
          {7'h00, 3'b011}: dec.op = SLTU;
          {7'h00, 3'b100}: dec.op = XOR;
          {7'h00, 3'b101}: dec.op = SRL;
          {7'h20, 3'b101}: dec.op = SRA;
          {7'h00, 3'b110}: dec.op = OR;
          {7'h00, 3'b111}: dec.op = AND;
          default:         ill = TRUE;
        endcase
      end
      default: ill = TRUE;
    endcase
    // illegal entries carry only the flag so issue never sees stray tags
    if (ill) begin
      dec = '0;
    end
    dec.illegal = ill;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage with in-order queue of decoded entries and flush
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input logic           clk,
  input logic           rst,
  input logic           rdy,
  decode_stage_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  dec_t            dec_in;
  dec_t            mem    [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  decode_logic u_decode_logic (
    .instr (bus.in_fetcher_instr),
    .dec   (dec_in)
  );

  // ready looks only at registered count, never at this cycle's pop
  assign bus.out_fetcher_ready = (count < FULL);
  assign bus.out_valid         = (count != '0);

  assign push = rdy & bus.in_fetcher_valid & bus.out_fetcher_ready & ~bus.in_flush;
  assign pop  = rdy & bus.out_valid & bus.in_issue_ready & ~bus.in_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]    <= '0;
        pc_mem[i] <= '0;
      end
    end else if (rdy) begin
      if (bus.in_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr]    <= dec_in;
          pc_mem[wr_ptr] <= bus.in_fetcher_pc;
          wr_ptr         <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.out_op      = mem[rd_ptr].op;
  assign bus.out_rd      = mem[rd_ptr].rd;
  assign bus.out_rs1     = mem[rd_ptr].rs1;
  assign bus.out_rs2     = mem[rd_ptr].rs2;
  assign bus.out_imm     = mem[rd_ptr].imm;
  assign bus.out_illegal = mem[rd_ptr].illegal;
  assign bus.out_pc      = pc_mem[rd_ptr];

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector bench for decode_stage
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs [NV];

  decode_stage_if #(.PC_W(32)) bus ();

  decode_stage #(.DEPTH(2), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [5:0] op, input logic ill,
                            input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_op"}, 32'(bus.out_op), 32'(op));
    check({tag, "_ill"}, 32'(bus.out_illegal), 32'(ill));
    check({tag, "_pc"}, bus.out_pc, pc);
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, ADDI,  5'd1, 5'd0, 5'd0, 32'd5,         1'b0};
    vecs[1]  = '{32'h00112623, SW,    5'd0, 5'd2, 5'd1, 32'd12,        1'b0};
    vecs[2]  = '{32'hFE000EE3, BEQ,   5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,  1'b0};
    vecs[3]  = '{32'h123452B7, LUI,   5'd5, 5'd0, 5'd0, 32'h12345000,  1'b0};
    vecs[4]  = '{32'hFFFFFFFF, NOP,   5'd0, 5'd0, 5'd0, 32'd0,         1'b1};
    vecs[5]  = '{32'h40309093, NOP,   5'd0, 5'd0, 5'd0, 32'd0,         1'b1};
    vecs[6]  = '{32'h00309093, SLLI,  5'd1, 5'd1, 5'd0, 32'd3,         1'b0};
    vecs[7]  = '{32'h4041D113, SRAI,  5'd2, 5'd3, 5'd0, 32'd4,         1'b0};
    vecs[8]  = '{32'h402081B3, SUB,   5'd3, 5'd1, 5'd2, 32'd0,         1'b0};
    vecs[9]  = '{32'hFFDFF0EF, JAL,   5'd1, 5'd0, 5'd0, 32'hFFFFFFFC,  1'b0};
    vecs[10] = '{32'h4020E1B3, NOP,   5'd0, 5'd0, 5'd0, 32'd0,         1'b1};
    vecs[11] = '{32'hFF832283, LW,    5'd5, 5'd6, 5'd0, 32'hFFFFFFF8,  1'b0};
    vecs[12] = '{32'h00003083, NOP,   5'd0, 5'd0, 5'd0, 32'd0,         1'b1};
    vecs[13] = '{32'hFFFFF397, AUIPC, 5'd7, 5'd0, 5'd0, 32'hFFFFF000,  1'b0};
    vecs[14] = '{32'h00209863, BNE,   5'd0, 5'd1, 5'd2, 32'd16,        1'b0};
    vecs[15] = '{32'h4062D233, SRA,   5'd4, 5'd5, 5'd6, 32'd0,         1'b0};
    vecs[16] = '{32'h00001067, NOP,   5'd0, 5'd0, 5'd0, 32'd0,         1'b1};

    rst = 1'b1;
    rdy = 1'b1;
    bus.in_fetcher_valid = 1'b0;
    bus.in_fetcher_instr = '0;
    bus.in_fetcher_pc    = '0;
    bus.in_flush         = 1'b0;
    bus.in_issue_ready   = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.out_fetcher_ready), 32'd1);
    check("rst_op", 32'(bus.out_op), 32'(NOP));
    check("rst_ill", 32'(bus.out_illegal), 32'd0);
    check("rst_rd", 32'(bus.out_rd), 32'd0);
    check("rst_rs1", 32'(bus.out_rs1), 32'd0);
    check("rst_rs2", 32'(bus.out_rs2), 32'd0);
    check("rst_imm", bus.out_imm, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);

    for (int i = 0; i < NV; i++) begin
      bus.in_fetcher_instr = vecs[i].instr;
      bus.in_fetcher_pc    = 32'h100 + 32'(i) * 4;
      bus.in_fetcher_valid = 1'b1;
      step();
      bus.in_fetcher_valid = 1'b0;
      check_head($sformatf("v%0d", i), vecs[i].op, vecs[i].ill, 32'h100 + 32'(i) * 4);
      check($sformatf("v%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_rs1", i), 32'(bus.out_rs1), 32'(vecs[i].rs1));
      check($sformatf("v%0d_rs2", i), 32'(bus.out_rs2), 32'(vecs[i].rs2));
      check($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
      bus.in_issue_ready = 1'b1;
      step();
      bus.in_issue_ready = 1'b0;
      check($sformatf("v%0d_drained", i), 32'(bus.out_valid), 32'd0);
    end

    // full queue: third instruction held until a pop frees a slot
    bus.in_fetcher_instr = 32'h00500093;
    bus.in_fetcher_valid = 1'b1;
    bus.in_fetcher_pc    = 32'hA00;
    step();
    check("full1_ready", 32'(bus.out_fetcher_ready), 32'd1);
    bus.in_fetcher_pc = 32'hA04;
    step();
    check("full2_ready", 32'(bus.out_fetcher_ready), 32'd0);
    bus.in_fetcher_pc = 32'hA08;
    step();
    check("full3_ready", 32'(bus.out_fetcher_ready), 32'd0);
    check_head("full3_head", ADDI, 1'b0, 32'hA00);
    bus.in_issue_ready = 1'b1;
    step();
    bus.in_issue_ready = 1'b0;
    check("pop_ready", 32'(bus.out_fetcher_ready), 32'd1);
    check_head("pop_head", ADDI, 1'b0, 32'hA04);
    step();
    bus.in_fetcher_valid = 1'b0;
    check("refill_ready", 32'(bus.out_fetcher_ready), 32'd0);
    bus.in_issue_ready = 1'b1;
    step();
    check_head("order_head", ADDI, 1'b0, 32'hA08);
    step();
    bus.in_issue_ready = 1'b0;
    check("order_empty", 32'(bus.out_valid), 32'd0);

    // simultaneous push and pop keeps count at one
    bus.in_fetcher_valid = 1'b1;
    bus.in_fetcher_pc    = 32'hB00;
    step();
    bus.in_fetcher_instr = 32'h402081B3;
    bus.in_fetcher_pc    = 32'hB04;
    bus.in_issue_ready   = 1'b1;
    step();
    bus.in_fetcher_valid = 1'b0;
    check_head("pp_head", SUB, 1'b0, 32'hB04);
    check("pp_ready", 32'(bus.out_fetcher_ready), 32'd1);
    step();
    bus.in_issue_ready = 1'b0;
    check("pp_empty", 32'(bus.out_valid), 32'd0);

    // flush with two queued entries and a valid input
    bus.in_fetcher_instr = 32'h00500093;
    bus.in_fetcher_valid = 1'b1;
    step();
    step();
    bus.in_flush = 1'b1;
    step();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_ready", 32'(bus.out_fetcher_ready), 32'd1);
    step();
    bus.in_flush         = 1'b0;
    bus.in_fetcher_valid = 1'b0;
    check("flush_drop", 32'(bus.out_valid), 32'd0);
    step();
    check("flush_after", 32'(bus.out_valid), 32'd0);

    // rdy low freezes the queue despite pending push and pop
    bus.in_fetcher_instr = 32'hFFFFFFFF;
    bus.in_fetcher_pc    = 32'hC00;
    bus.in_fetcher_valid = 1'b1;
    step();
    check_head("rdy_head", NOP, 1'b1, 32'hC00);
    rdy                  = 1'b0;
    bus.in_fetcher_instr = 32'h40309093;
    bus.in_fetcher_pc    = 32'hC04;
    bus.in_issue_ready   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_head($sformatf("frz%0d", c), NOP, 1'b1, 32'hC00);
      check($sformatf("frz%0d_ready", c), 32'(bus.out_fetcher_ready), 32'd1);
    end
    rdy                  = 1'b1;
    bus.in_fetcher_valid = 1'b0;
    step();
    bus.in_issue_ready = 1'b0;
    check("frz_pop", 32'(bus.out_valid), 32'd0);

    // reset mid-operation clears storage as well as pointers
    bus.in_fetcher_instr = 32'h123452B7;
    bus.in_fetcher_pc    = 32'hD00;
    bus.in_fetcher_valid = 1'b1;
    step();
    bus.in_fetcher_valid = 1'b0;
    check_head("mrst_pre", LUI, 1'b0, 32'hD00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_op", 32'(bus.out_op), 32'(NOP));
    check("mrst_rd", 32'(bus.out_rd), 32'd0);
    check("mrst_imm", bus.out_imm, 32'd0);
    check("mrst_pc", bus.out_pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Buffered RV32I decode stage between the fetcher and issue logic (ROB/RS). Accepts one instruction per cycle over a valid/ready handshake and fully decodes it: inside opcode, register tags, sign-extended immediate and illegal flag. Decoded entries go into a parametrised in-order queue. The queue decouples fetch from issue stalls and is cleared by a pipeline flush.

## Interface
Parameters:
- `DEPTH`, 2: decoded-entry queue depth, power of two, ≥2.
- `PC_W`, 32: PC width carried through.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; low freezes all state.
- `in_fetcher_valid` in 1: instruction/PC valid.
- `in_fetcher_instr` in `DATA_WIDTH`: raw instruction.
- `in_fetcher_pc` in `PC_W`: instruction PC.
- `out_fetcher_ready` out 1: stage can accept this cycle.
- `in_flush` in 1: mispredict/flush; discard all entries.
- `in_issue_ready` in 1: issue consumes head entry.
- `out_valid` out 1: head entry valid.
- `out_op` out `INSIDE_OPCODE_WIDTH`: inside opcode of head.
- `out_rd`, `out_rs1`, `out_rs2` out `REG_TAG_WIDTH`: register tags of head.
- `out_imm` out `DATA_WIDTH`: sign-extended immediate of head.
- `out_pc` out `PC_W`: PC of head.
- `out_illegal` out 1: head instruction is not legal RV32I.

## Operation
- Push: `rdy & in_fetcher_valid & out_fetcher_ready & !in_flush`. Pop: `rdy & out_valid & in_issue_ready & !in_flush`.
- Push and pop may both fire in one cycle. Count is unchanged and pointers advance.
- Decode is combinational on the input and registered into the queue at the push edge.
- Decoding covers all 37 RV32I ops: LUI, AUIPC, JAL, JALR, B-type ×6, loads ×5, stores ×3, I-ALU ×9, R-ALU ×10.
- Immediates by format:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]} sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - Shift-immediate: {27'b0, shamt}.
  - R-type: 0.
- `out_rd` is forced to 0 for B and S types.
- `out_rs1` is forced to 0 for LUI, AUIPC and JAL.
- `out_rs2` is forced to 0 for every type except R, B and S.
- An instruction is illegal when any of these holds:
  - the opcode is unknown;
  - funct3 is reserved;
  - funct7 is not 0x00/0x20 where funct7 is checked;
  - funct7 is not 0 for SLLI, ADD-family non-SUB, or R-ops other than SUB/SRA.
- An illegal instruction is still enqueued with `out_op=NOP` and `out_illegal=1`.
- Flush: pointers and count go to 0. Any input presented in the flush cycle is dropped. Flush takes priority over push and pop.
- When `rdy` is low, there is no push, no pop and no state change. Outputs hold.

## Timing
- Latency: an instruction pushed at edge N appears at the outputs (`out_valid=1`) after edge N, i.e. in cycle N+1.
- `out_fetcher_ready = (count < DEPTH)` is registered-state only. It does not account for a same-cycle pop, so there is no ready→valid combinational path.
- Head outputs are driven from queue storage, so they are stable while `out_valid & !in_issue_ready`.
- Output values after reset:
  - `out_valid=0`, `out_fetcher_ready=1`.
  - `out_op=NOP`, `out_illegal=0`.
  - `out_rd`, `out_rs1`, `out_rs2`, `out_imm`, `out_pc` = 0.
- Reset asserted mid-operation has the same effect as a flush and also clears storage.
- Pointers wrap modulo `DEPTH`. Count width is clog2(`DEPTH`)+1.
- Full with a simultaneous pop: the push is refused that cycle (ready was already low). `out_fetcher_ready` rises the next cycle.
- Empty with a simultaneous push: no pop. The entry is visible next cycle.

## Structure
- Shared defines package holds:
  - `DATA_WIDTH`, `REG_TAG_WIDTH`, `INSIDE_OPCODE_WIDTH`, `OPCODE_WIDTH`;
  - all inside-opcode constants, with NOP added;
  - the RV32I major-opcode constants;
  - `TRUE`/`FALSE`.
- Sub-module `decode_logic` is purely combinational. It maps instr → {op, rd, rs1, rs2, imm, illegal}.
- The parent holds the queue, the handshake and the flush logic.

## Test plan
- ADDI x1,x0,5 (0x00500093), issue ready → next cycle `out_valid=1`, `out_op=ADDI`, `out_rd=1`, `out_rs1=0`, `out_imm=5`.
- SW x1,12(x2) (0x00112623) → `out_op=SW`, `out_rs1=2`, `out_rs2=1`, `out_rd=0`, `out_imm=12`.
- BEQ x0,x0,-4 (0xFE000EE3) → `out_op=BEQ`, `out_imm=0xFFFFFFFC`. LUI x5,0x12345 (0x123452B7) → `out_rd=5`, `out_imm=0x12345000`.
- `DEPTH=2`, `in_issue_ready=0`, three back-to-back valid instructions:
  - `out_fetcher_ready` falls after the 2nd push and the 3rd is held.
  - Pop once → ready rises the following cycle, and order is preserved.
- Two entries queued, `in_flush=1` with a valid input → next cycle `out_valid=0`, count 0, and the input is dropped.
- Instr 0xFFFFFFFF and SLLI with funct7=0x20 → enqueued with `out_illegal=1`, `out_op=NOP`. With `rdy=0` for 3 cycles, outputs and ready are unchanged.
